multi_mode_mac_dsp: RTL and testbench
=====================================

MULTI_MODE_MAC_DSP -- requirements
Module: multi_mode_mac_dsp

Interface
REQ-001 Parameter N, 16, A operand width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter M, 16, B operand width; SHALL be a multiple of 4 and at least 8.
REQ-003 Parameter PIPES, 1, extra pipeline register stages after the input register; legal range 0..3.
REQ-004 Parameter ACC_W, 40, accumulator width; SHALL be at least N+M.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  operand valid; one operation accepted per cycle when high, no back-pressure.
REQ-008 mode  in  2  0 = one NxM product, 1 = two (N/2)x(M/2) lanes, 2 = four (N/4)x(M/4) lanes, 3 = reserved.
REQ-009 acc_en  in  1  add this operation's lane-product sum into the accumulator.
REQ-010 acc_clr  in  1  clear the accumulator before this operation's contribution.
REQ-011 aa  in  N  operand A, unsigned; lane k = aa[k*N/L +: N/L], where L is the lane count.
REQ-012 bb  in  M  operand B, unsigned; lane k = bb[k*M/L +: M/L].
REQ-013 out  out  N+M  packed lane products; lane k = out[k*(N+M)/L +: (N+M)/L].
REQ-014 out_valid  out  1  out, acc_out and out_err are valid for this operation.
REQ-015 acc_out  out  ACC_W  accumulator value after this operation's update.
REQ-016 out_err  out  1  operation was issued with mode 3.
REQ-017 acc_ovf  out  1  sticky accumulator wrap flag.

Function
REQ-018 Input stage: when start=1, register aa, bb, mode, acc_en and acc_clr. When start=0, the operand registers hold their values and the valid bit is set to 0.
REQ-019 Every operation carries its own mode, acc_en and acc_clr through the pipeline. A mode change between consecutive cycles SHALL NOT corrupt in-flight operations.
REQ-020 Latency from start sampled high to out_valid high SHALL be exactly 1+PIPES cycles; throughput SHALL be one operation per cycle.
REQ-021 Lane products SHALL be full-width and unsigned, so no truncation is possible; lane k's product occupies lane k's output field.
REQ-022 Mode 3: out = 0 and out_err = 1 with out_valid. The accumulator and acc_ovf SHALL be unchanged, even if acc_en or acc_clr is set.
REQ-023 On an output cycle, the accumulator update SHALL be:
  - acc_clr=1, acc_en=0: acc = 0.
  - acc_clr=1, acc_en=1: acc = S.
  - acc_clr=0, acc_en=1: acc = acc + S, modulo 2^ACC_W.
  - both 0: unchanged.
  where S is the zero-extended sum of all lane products of that operation.
REQ-024 acc_ovf SHALL set when an addition carries out of bit ACC_W-1. It SHALL clear only on an acc_clr operation or on reset.
REQ-025 acc_out SHALL reflect the post-update accumulator in the same cycle out_valid=1. It SHALL hold its value while out_valid=0.
REQ-026 out SHALL hold the last valid result while out_valid=0.
REQ-027 out_valid SHALL be high for exactly one cycle per accepted operation. Back-to-back starts SHALL give back-to-back out_valid cycles.
REQ-028 PIPES=0 SHALL give latency 1 with no combinational path from the inputs to any output.

Reset
REQ-029 While rst_n=0, all of the following SHALL be 0: out, out_valid, acc_out, out_err, acc_ovf, the internal accumulator, and all pipeline valid bits.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; no out_valid may appear for them after reset releases.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Verification (N=M=16, PIPES=1, ACC_W=40, unsigned)
REQ-032 Mode 0: aa=0xFFFF, bb=0xFFFF, start for 1 cycle -> 2 cycles later out=0xFFFE0001, out_valid pulses once.
REQ-033 Mode 1, then mode 2, back-to-back: aa=0x0302, bb=0x0504 -> out=0x000F0008; then mode 2 with aa=0x4321, bb=0x1111 -> out=0x04030201, with consecutive out_valid cycles.
REQ-034 Accumulate sequence:
  - Op 1: mode 2, aa=0x4321, bb=0x1111, acc_clr=1, acc_en=1 -> acc_out=10.
  - Op 2: same operands, acc_en=1 -> acc_out=20.
  - Op 3: acc_clr=1, acc_en=0 -> acc_out=0.
REQ-035 Wrap: preload acc_out=0xFFFFFFFFFF via 256 mode-0 ops of 0xFFFF*0xFFFF plus a remainder op, then add 1 (aa=1, bb=1, acc_en=1) -> acc_out=0 and acc_ovf=1. A following acc_clr op clears acc_ovf.
REQ-036 Mode 3 with acc_en=1 -> out=0, out_err=1, and acc_out unchanged from its previous value.
REQ-037 Reset mid-flight: start an op, then assert rst_n=0 on the next cycle -> no out_valid appears, and all outputs read 0 after release.
REQ-038 Compare every out_valid result against a cycle-accurate behavioural model; the error count at end of test SHALL be 0 over 200 random ops with random mode, acc_en and acc_clr.

Source files
------------

// File: rtl/multi_mode_mac_dsp_if.sv
// Operand/result bundle for multi_mode_mac_dsp.
// The master drives operations in and the slave returns results.
interface multi_mode_mac_dsp_if #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int ACC_W = 40
);
  logic             start;
  logic [1:0]       mode;
  logic             acc_en;
  logic             acc_clr;
  logic [N-1:0]     aa;
  logic [M-1:0]     bb;
  logic [N+M-1:0]   out;
  logic             out_valid;
  logic [ACC_W-1:0] acc_out;
  logic             out_err;
  logic             acc_ovf;

  modport master (
    output start, mode, acc_en, acc_clr, aa, bb,
    input  out, out_valid, acc_out, out_err, acc_ovf
  );

  modport slave (
    input  start, mode, acc_en, acc_clr, aa, bb,
    output out, out_valid, acc_out, out_err, acc_ovf
  );
endinterface

// File: rtl/multi_mode_mac_dsp.sv
// Multi-mode unsigned MAC: one full-width product, or 2/4 packed narrow-lane products,
// with an optional accumulator and a sticky wrap flag.
module multi_mode_mac_dsp #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int PIPES = 1,
  parameter int ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multi_mode_mac_dsp_if.slave  bus
);
  localparam int PW = N + M;

  typedef struct packed {
    logic         valid;
    logic [1:0]   mode;
    logic         en;
    logic         clr;
    logic [N-1:0] a;
    logic [M-1:0] b;
  } stage_t;

  // Entry 0 is the input register; entries 1..PIPES are the extra delay stages.
  // Each operation carries its own mode/en/clr so mode changes never disturb in-flight ops.
  stage_t stg_reg [0:PIPES];
  stage_t last_stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= PIPES; i++) stg_reg[i] <= '0;
    end else begin
      stg_reg[0].valid <= bus.start;
      if (bus.start) begin
        stg_reg[0].mode <= bus.mode;
        stg_reg[0].en   <= bus.acc_en;
        stg_reg[0].clr  <= bus.acc_clr;
        stg_reg[0].a    <= bus.aa;
        stg_reg[0].b    <= bus.bb;
      end
      for (int i = 1; i <= PIPES; i++) stg_reg[i] <= stg_reg[i-1];
    end
  end

  assign last_stg = stg_reg[PIPES];

  // Every lane product is zero-extended to its full output field, so nothing truncates.
  logic [PW-1:0]   prod1;
  logic [PW/2-1:0] prod2 [2];
  logic [PW/4-1:0] prod4 [4];
  logic [PW-1:0]   pack2;
  logic [PW-1:0]   pack4;

  assign prod1 = {{M{1'b0}}, last_stg.a} * {{N{1'b0}}, last_stg.b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane2
      assign prod2[gi] = {{(M/2){1'b0}}, last_stg.a[gi*(N/2) +: N/2]}
                       * {{(N/2){1'b0}}, last_stg.b[gi*(M/2) +: M/2]};
      assign pack2[gi*(PW/2) +: PW/2] = prod2[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_lane4
      assign prod4[gi] = {{(M/4){1'b0}}, last_stg.a[gi*(N/4) +: N/4]}
                       * {{(N/4){1'b0}}, last_stg.b[gi*(M/4) +: M/4]};
      assign pack4[gi*(PW/4) +: PW/4] = prod4[gi];
    end
  endgenerate

  logic [ACC_W-1:0] sum2;
  logic [ACC_W-1:0] sum4;
  logic [PW-1:0]    res_out;
  logic [ACC_W-1:0] res_sum;
  logic [ACC_W:0]   acc_add;
  logic [ACC_W-1:0] acc_reg;
  logic [PW-1:0]    out_reg;
  logic             out_valid_reg;
  logic             err_reg;
  logic             ovf_reg;

  always_comb begin
    sum2 = '0;
    sum4 = '0;
    for (int k = 0; k < 2; k++) sum2 = sum2 + ACC_W'(prod2[k]);
    for (int k = 0; k < 4; k++) sum4 = sum4 + ACC_W'(prod4[k]);
    res_out = '0;
    res_sum = '0;
    case (last_stg.mode)
      2'd0: begin res_out = prod1; res_sum = ACC_W'(prod1); end
      2'd1: begin res_out = pack2; res_sum = sum2; end
      2'd2: begin res_out = pack4; res_sum = sum4; end
      default: begin res_out = '0; res_sum = '0; end
    endcase
    acc_add = {1'b0, acc_reg} + {1'b0, res_sum};
  end

  // Output stage is fully registered, so even PIPES=0 has no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      acc_reg       <= '0;
      err_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      out_valid_reg <= last_stg.valid;
      if (last_stg.valid) begin
        out_reg <= res_out;
        err_reg <= (last_stg.mode == 2'd3);
        if (last_stg.mode != 2'd3) begin
          if (last_stg.clr) begin
            acc_reg <= last_stg.en ? res_sum : '0;
            ovf_reg <= 1'b0;
          end else if (last_stg.en) begin
            acc_reg <= acc_add[ACC_W-1:0];
            if (acc_add[ACC_W]) ovf_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.acc_out   = acc_reg;
  assign bus.out_err   = err_reg;
  assign bus.acc_ovf   = ovf_reg;
endmodule

// File: tb/tb_multi_mode_mac_dsp.sv
// Directed and random checks of multi_mode_mac_dsp against a lane-arithmetic reference model.
module tb_multi_mode_mac_dsp;
  localparam int PIPES = 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycle;

  multi_mode_mac_dsp_if #(.N(16), .M(16), .ACC_W(40)) m_if ();

  multi_mode_mac_dsp #(.N(16), .M(16), .PIPES(PIPES), .ACC_W(40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] out;
    logic        err;
    logic [39:0] acc;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  exp_t        shown;
  logic [39:0] model_acc;
  logic        model_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: split operands into L equal lanes, multiply each, pack and sum.
  function automatic void model_lanes(input logic [1:0] md, input logic [15:0] a,
                                      input logic [15:0] b, output logic [63:0] o,
                                      output logic [63:0] s);
    int lanes, wa, pw;
    logic [63:0] la, lb, p;
    lanes = (md == 2'd0) ? 1 : (md == 2'd1) ? 2 : 4;
    wa = 16 / lanes;
    pw = 32 / lanes;
    o = 0;
    s = 0;
    for (int k = 0; k < lanes; k++) begin
      la = (64'(a) >> (k * wa)) & ((64'd1 << wa) - 1);
      lb = (64'(b) >> (k * wa)) & ((64'd1 << wa) - 1);
      p  = la * lb;
      o  = o | (p << (k * pw));
      s  = s + p;
    end
  endfunction

  task automatic check_outputs();
    if (q.size() > 0 && q[0].due == cycle) begin
      shown = q.pop_front();
      chk("out_valid_hi", 64'(m_if.out_valid), 64'd1);
    end else begin
      chk("out_valid_lo", 64'(m_if.out_valid), 64'd0);
    end
    chk("out", 64'(m_if.out), 64'(shown.out));
    chk("out_err", 64'(m_if.out_err), 64'(shown.err));
    chk("acc_out", 64'(m_if.acc_out), 64'(shown.acc));
    chk("acc_ovf", 64'(m_if.acc_ovf), 64'(shown.ovf));
    $display("cycle %0d: valid=%0d out=%h err=%0d acc=%h ovf=%0d", cycle, m_if.out_valid,
             m_if.out, m_if.out_err, m_if.acc_out, m_if.acc_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    shown     = '{0, 32'd0, 1'b0, 40'd0, 1'b0};
    model_acc = '0;
    model_ovf = 1'b0;
  endtask

  task automatic issue(input logic [1:0] md, input logic en, input logic clr,
                       input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [63:0] o, s, t;
    m_if.start   = 1'b1;
    m_if.mode    = md;
    m_if.acc_en  = en;
    m_if.acc_clr = clr;
    m_if.aa      = a;
    m_if.bb      = b;
    model_lanes(md, a, b, o, s);
    e.due = cycle + 2 + PIPES;
    if (md == 2'd3) begin
      e.out = '0;
      e.err = 1'b1;
    end else begin
      e.out = o[31:0];
      e.err = 1'b0;
      if (clr) begin
        model_acc = en ? s[39:0] : 40'd0;
        model_ovf = 1'b0;
      end else if (en) begin
        t = {24'd0, model_acc} + s;
        if (t >= 64'h100_0000_0000) model_ovf = 1'b1;
        model_acc = t[39:0];
      end
    end
    e.acc = model_acc;
    e.ovf = model_ovf;
    q.push_back(e);
    step();
    m_if.start = 1'b0;
  endtask

  task automatic idle();
    m_if.start = 1'b0;
    m_if.aa    = 16'($urandom);
    m_if.bb    = 16'($urandom);
    m_if.mode  = 2'($urandom);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    rst_n  = 1'b0;
    m_if.start = 1'b0; m_if.mode = 2'd0; m_if.acc_en = 1'b0; m_if.acc_clr = 1'b0;
    m_if.aa = '0; m_if.bb = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    check_outputs();
    step();
    step();
    rst_n = 1'b1;

    // Full-width product, issued right after release
    issue(2'd0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    idle();
    idle();
    chk("r032_out", 64'(m_if.out), 64'hFFFE0001);
    idle();

    // Mode switch back-to-back
    issue(2'd1, 1'b0, 1'b0, 16'h0302, 16'h0504);
    issue(2'd2, 1'b0, 1'b0, 16'h4321, 16'h1111);
    idle();
    chk("r033_m1", 64'(m_if.out), 64'h000F0008);
    idle();
    chk("r033_m2", 64'(m_if.out), 64'h04030201);

    // Accumulate sequence
    issue(2'd2, 1'b1, 1'b1, 16'h4321, 16'h1111);
    issue(2'd2, 1'b1, 1'b0, 16'h4321, 16'h1111);
    issue(2'd2, 1'b0, 1'b1, 16'h4321, 16'h1111);
    chk("r034_op1", 64'(m_if.acc_out), 64'd10);
    idle();
    chk("r034_op2", 64'(m_if.acc_out), 64'd20);
    idle();
    chk("r034_op3", 64'(m_if.acc_out), 64'd0);

    // Wrap: 256 * FFFE0001 + FFFF*200 + FF = FF_FFFF_FFFF, then +1
    for (int i = 0; i < 256; i++) issue(2'd0, 1'b1, (i == 0), 16'hFFFF, 16'hFFFF);
    issue(2'd0, 1'b1, 1'b0, 16'hFFFF, 16'h0200);
    issue(2'd0, 1'b1, 1'b0, 16'h00FF, 16'h0001);
    idle();
    idle();
    chk("r035_pre", 64'(m_if.acc_out), 64'hFF_FFFF_FFFF);
    issue(2'd0, 1'b1, 1'b0, 16'h0001, 16'h0001);
    idle();
    idle();
    chk("r035_wrap_acc", 64'(m_if.acc_out), 64'd0);
    chk("r035_wrap_ovf", 64'(m_if.acc_ovf), 64'd1);
    issue(2'd0, 1'b0, 1'b1, 16'h0001, 16'h0001);
    idle();
    idle();
    chk("r035_clr_ovf", 64'(m_if.acc_ovf), 64'd0);

    // Reserved mode leaves the accumulator alone
    issue(2'd2, 1'b1, 1'b0, 16'h4321, 16'h1111);
    issue(2'd3, 1'b1, 1'b0, 16'h1234, 16'h5678);
    idle();
    idle();
    chk("r036_out", 64'(m_if.out), 64'd0);
    chk("r036_err", 64'(m_if.out_err), 64'd1);
    chk("r036_acc", 64'(m_if.acc_out), 64'd10);

    // Reset mid-flight
    issue(2'd0, 1'b1, 1'b0, 16'h1234, 16'h5678);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle();

    // Random operations with random gaps
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(3) == 0) idle();
      issue(2'($urandom), ($urandom_range(3) != 0), ($urandom_range(5) == 0),
            16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < PIPES + 3; i++) idle();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
